// File: rtl/alu_acc_ctrl.sv
// alu_acc_ctrl: sequences one ADD/SUB/ACC/CLR request through an external
// 8-bit ripple-carry adder, registers result, flags and accumulator.
module alu_acc_ctrl (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [1:0] op,
    input  logic [7:0] opA,
    input  logic [7:0] opB,
    output logic [7:0] rca_A,
    output logic [7:0] rca_B,
    output logic       rca_Cin,
    input  logic [7:0] rca_Sum,
    input  logic       rca_Cout,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] result,
    output logic       flag_c,
    output logic       flag_z,
    output logic       flag_n,
    output logic       flag_v,
    output logic [7:0] acc
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EXEC = 2'b01,
        HOLD = 2'b10
    } state_t;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_ACC = 2'b10,
        OP_CLR = 2'b11
    } op_t;

    state_t     state;
    state_t     state_n;
    op_t        op_q;
    logic [7:0] a_q;
    logic [7:0] b_q;
    logic       capture;
    logic       commit;
    logic       ovf;

    // State register; reset forces IDLE without waiting for a clock
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next state and handshake outputs; unused encoding falls back to IDLE
    always_comb begin
        state_n   = IDLE;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        capture   = 1'b0;
        commit    = 1'b0;
        case (state)
            IDLE: begin
                in_ready = ~rst;
                if (in_valid) begin
                    capture = 1'b1;
                    state_n = EXEC;
                end else begin
                    state_n = IDLE;
                end
            end
            EXEC: begin
                commit  = 1'b1;
                state_n = HOLD;
            end
            HOLD: begin
                out_valid = 1'b1;
                state_n   = out_ready ? IDLE : HOLD;
            end
            default: state_n = IDLE;
        endcase
    end

    // Request capture; the adder is fed only from these registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q <= OP_ADD;
            a_q  <= 8'h00;
            b_q  <= 8'h00;
        end else if (capture) begin
            op_q <= op_t'(op);
            a_q  <= opA;
            b_q  <= opB;
        end
    end

    // Adder operand selection from the captured request
    always_comb begin
        rca_A   = 8'h00;
        rca_B   = 8'h00;
        rca_Cin = 1'b0;
        case (op_q)
            OP_ADD: begin
                rca_A = a_q;
                rca_B = b_q;
            end
            OP_SUB: begin
                rca_A   = a_q;
                rca_B   = b_q;
                rca_Cin = 1'b1;
            end
            OP_ACC: begin
                rca_A = acc;
                rca_B = b_q;
            end
            OP_CLR: begin
                rca_A = 8'h00;
                rca_B = 8'h00;
            end
            default: begin
                rca_A = 8'h00;
                rca_B = 8'h00;
            end
        endcase
    end

    // Signed overflow: operands agree in sign but the sum does not
    assign ovf = (rca_A[7] == (rca_B[7] ^ rca_Cin)) && (rca_Sum[7] != rca_A[7]);

    // Result, flags and accumulator update once the ripple has settled
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result <= 8'h00;
            acc    <= 8'h00;
            flag_c <= 1'b0;
            flag_z <= 1'b0;
            flag_n <= 1'b0;
            flag_v <= 1'b0;
        end else if (commit) begin
            if (op_q == OP_CLR) begin
                result <= 8'h00;
                acc    <= 8'h00;
                flag_c <= 1'b0;
                flag_z <= 1'b1;
                flag_n <= 1'b0;
                flag_v <= 1'b0;
            end else begin
                result <= rca_Sum;
                acc    <= rca_Sum;
                flag_c <= rca_Cout;
                flag_z <= (rca_Sum == 8'h00);
                flag_n <= rca_Sum[7];
                flag_v <= ovf;
            end
        end
    end

endmodule

// File: tb/tb_alu_acc_ctrl.sv
// tb_alu_acc_ctrl: directed vectors against an arithmetic reference model,
// with per-cycle comparison and literal expectations for key vectors.
module tb_alu_acc_ctrl;

    localparam logic [1:0] ADD = 2'b00;
    localparam logic [1:0] SUB = 2'b01;
    localparam logic [1:0] ACC = 2'b10;
    localparam logic [1:0] CLR = 2'b11;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [1:0] op;
    logic [7:0] opA;
    logic [7:0] opB;
    logic [7:0] rca_A;
    logic [7:0] rca_B;
    logic       rca_Cin;
    logic [7:0] rca_Sum;
    logic       rca_Cout;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] result;
    logic       flag_c;
    logic       flag_z;
    logic       flag_n;
    logic       flag_v;
    logic [7:0] acc;

    int total = 0;
    int bad = 0;

    alu_acc_ctrl dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .opA(opA), .opB(opB),
        .rca_A(rca_A), .rca_B(rca_B), .rca_Cin(rca_Cin),
        .rca_Sum(rca_Sum), .rca_Cout(rca_Cout),
        .out_valid(out_valid), .out_ready(out_ready), .result(result),
        .flag_c(flag_c), .flag_z(flag_z), .flag_n(flag_n), .flag_v(flag_v),
        .acc(acc)
    );

    // External ripple-carry stage: inverts B and adds Cin when subtracting
    logic [8:0] rca_full;
    assign rca_full = {1'b0, rca_A} + {1'b0, (rca_Cin ? ~rca_B : rca_B)}
                    + {8'h00, rca_Cin};
    assign rca_Sum  = rca_full[7:0];
    assign rca_Cout = rca_full[8];

    always #5 clk = ~clk;

    // Reference model: plain integer arithmetic, returns {c,z,n,v,res}
    function automatic logic [11:0] calc(input logic [1:0] o,
                                         input logic [7:0] a,
                                         input logic [7:0] b,
                                         input logic [7:0] cur);
        int x, y, s, sx, sy, sv;
        logic [7:0] r;
        logic c, v;
        if (o == CLR) return {1'b0, 1'b1, 1'b0, 1'b0, 8'h00};
        x  = (o == ACC) ? int'(cur) : int'(a);
        y  = int'(b);
        sx = (o == ACC) ? int'($signed(cur)) : int'($signed(a));
        sy = int'($signed(b));
        if (o == SUB) begin
            s  = x - y;
            c  = (x >= y);
            sv = sx - sy;
        end else begin
            s  = x + y;
            c  = (s > 255);
            sv = sx + sy;
        end
        r = 8'(s);
        v = (sv > 127) || (sv < -128);
        return {c, (r == 8'h00), r[7], v, r};
    endfunction

    logic       m_busy = 1'b0;
    logic       m_valid = 1'b0;
    logic [1:0] m_op = 2'b00;
    logic [7:0] m_a = 8'h00;
    logic [7:0] m_b = 8'h00;
    logic [7:0] m_res = 8'h00;
    logic [7:0] m_acc = 8'h00;
    logic       m_c = 1'b0;
    logic       m_z = 1'b0;
    logic       m_n = 1'b0;
    logic       m_v = 1'b0;
    logic [11:0] m_out;

    assign m_out = calc(m_op, m_a, m_b, m_acc);

    // Model: accept, settle one cycle, then hold until taken
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy <= 1'b0; m_valid <= 1'b0;
            m_op <= 2'b00; m_a <= 8'h00; m_b <= 8'h00;
            m_res <= 8'h00; m_acc <= 8'h00;
            m_c <= 1'b0; m_z <= 1'b0; m_n <= 1'b0; m_v <= 1'b0;
        end else if (!m_busy) begin
            if (in_valid) begin
                m_busy <= 1'b1;
                m_op <= op; m_a <= opA; m_b <= opB;
            end
        end else if (!m_valid) begin
            m_valid <= 1'b1;
            {m_c, m_z, m_n, m_v, m_res} <= m_out;
            m_acc <= m_out[7:0];
        end else if (out_ready) begin
            m_busy <= 1'b0;
            m_valid <= 1'b0;
        end
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model
    task automatic cycle_check();
        logic [7:0] ea, eb;
        chk("in_ready", 32'(in_ready), 32'(!m_busy && !rst));
        chk("out_valid", 32'(out_valid), 32'(m_valid));
        chk("result", 32'(result), 32'(m_res));
        chk("flags", 32'({flag_c, flag_z, flag_n, flag_v}),
            32'({m_c, m_z, m_n, m_v}));
        chk("acc", 32'(acc), 32'(m_acc));
        if (m_busy && !m_valid) begin
            ea = (m_op == ACC) ? m_acc : (m_op == CLR) ? 8'h00 : m_a;
            eb = (m_op == CLR) ? 8'h00 : m_b;
            chk("rca_A", 32'(rca_A), 32'(ea));
            chk("rca_B", 32'(rca_B), 32'(eb));
            chk("rca_Cin", 32'(rca_Cin), 32'(m_op == SUB));
        end
    endtask

    task automatic step();
        @(negedge clk);
        cycle_check();
    endtask

    task automatic do_op(input logic [1:0] o, input logic [7:0] a,
                         input logic [7:0] b, output int lat,
                         output logic cin_exec);
        op = o; opA = a; opB = b; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        cin_exec = rca_Cin;
        lat = 1;
        while (!out_valid && lat < 10) begin
            step();
            lat++;
        end
        chk("out_valid_seen", 32'(out_valid), 32'd1);
    endtask

    task automatic take();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    int   lat;
    logic cin;

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        op = 2'b00; opA = 8'h00; opB = 8'h00;
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_result", 32'(result), 32'd0);
        step();
        step();
        rst = 1'b0;
        step();
        chk("in_ready_after_rst", 32'(in_ready), 32'd1);

        do_op(ADD, 8'h7F, 8'h01, lat, cin);
        chk("add_latency", 32'(lat), 32'd2);
        chk("add_res", 32'(result), 32'h80);
        chk("add_czvn", 32'({flag_c, flag_z, flag_n, flag_v}), 32'b0011);
        take();

        do_op(SUB, 8'h05, 8'h05, lat, cin);
        chk("sub_cin", 32'(cin), 32'd1);
        chk("sub0_res", 32'(result), 32'h00);
        chk("sub0_czvn", 32'({flag_c, flag_z, flag_n, flag_v}), 32'b1100);
        take();

        do_op(SUB, 8'h03, 8'h05, lat, cin);
        chk("subneg_res", 32'(result), 32'hFE);
        chk("subneg_czvn", 32'({flag_c, flag_z, flag_n, flag_v}), 32'b0010);
        take();

        do_op(SUB, 8'h80, 8'h01, lat, cin);
        chk("subovf_res", 32'(result), 32'h7F);
        chk("subovf_v", 32'(flag_v), 32'd1);
        take();

        do_op(ADD, 8'hFF, 8'h01, lat, cin);
        chk("addwrap_res", 32'(result), 32'h00);
        chk("addwrap_cz", 32'({flag_c, flag_z}), 32'b11);
        take();

        do_op(CLR, 8'h55, 8'hAA, lat, cin);
        chk("clr_acc", 32'(acc), 32'h00);
        chk("clr_z", 32'(flag_z), 32'd1);
        take();
        do_op(ACC, 8'h00, 8'hFF, lat, cin);
        chk("acc1_acc", 32'(acc), 32'hFF);
        chk("acc1_c", 32'(flag_c), 32'd0);
        take();
        do_op(ACC, 8'h00, 8'hFF, lat, cin);
        chk("acc2_acc", 32'(acc), 32'hFE);
        chk("acc2_c", 32'(flag_c), 32'd1);
        take();

        do_op(ADD, 8'h40, 8'h40, lat, cin);
        for (int i = 1; i <= 5; i++) begin
            op = SUB; opA = 8'(8'h11 * i); opB = 8'(8'h07 * i);
            in_valid = 1'b1;
            step();
            chk("hold_in_ready", 32'(in_ready), 32'd0);
            chk("hold_res", 32'(result), 32'h80);
            chk("hold_acc", 32'(acc), 32'h80);
            chk("hold_v", 32'(flag_v), 32'd1);
        end
        in_valid = 1'b0;
        take();

        do_op(CLR, 8'h00, 8'h00, lat, cin);
        take();
        op = ADD; opA = 8'h10; opB = 8'h20; in_valid = 1'b1;
        @(posedge clk);
        #1;
        chk("exec_rca_A", 32'(rca_A), 32'h10);
        #1;
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("arst_rca", 32'({rca_A, rca_B, rca_Cin}), 32'd0);
        chk("arst_outs", 32'({in_ready, out_valid, result}), 32'd0);
        chk("arst_acc", 32'(acc), 32'h00);
        chk("arst_flags", 32'({flag_c, flag_z, flag_n, flag_v}), 32'd0);
        step();
        rst = 1'b0;
        step();
        chk("post_rst_ready", 32'(in_ready), 32'd1);
        do_op(ADD, 8'h01, 8'h01, lat, cin);
        chk("post_rst_res", 32'(result), 32'h02);
        chk("post_rst_acc", 32'(acc), 32'h02);
        take();
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_acc_ctrl.md
ALU_ACC_CTRL -- requirements
Module: alu_acc_ctrl

Interface
REQ-001 The block SHALL have no parameters; datapath width SHALL be fixed at 8 bits to match the 8-bit ripple-carry add/sub stage it drives.
REQ-002 clk  input  1  the single clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  the reset, asynchronous and active-high.
REQ-004 in_valid  input  1  the upstream request is valid.
REQ-005 in_ready  output  1  the block accepts a request this cycle.
REQ-006 op  input  2  operation: 00 ADD (opA+opB), 01 SUB (opA-opB), 10 ACC (acc+opB), 11 CLR.
REQ-007 opA, opB  input  8 each  operands.
REQ-008 rca_A, rca_B  output  8 each  operands to the adder stage.
REQ-009 rca_Cin  output  1  adder carry-in; the adder stage inverts B internally when Cin=1, so Cin=1 selects subtract.
REQ-010 rca_Sum  input  8, rca_Cout  input  1  the adder stage's combinational result.
REQ-011 out_valid  output  1  the result and flags are valid.
REQ-012 out_ready  input  1  the downstream consumer takes the result.
REQ-013 result  output  8  the registered sum or difference.
REQ-014 flag_c, flag_z, flag_n, flag_v  output  1 each  the carry, zero, negative and signed-overflow flags.
REQ-015 acc  output  8  the accumulator register.

Function
REQ-016 The FSM SHALL have exactly three states, IDLE, EXEC and HOLD, with a two-bit encoding; the remaining encoding SHALL return to IDLE on the next edge.
REQ-017 in_ready SHALL be 1 only in IDLE with rst low.
REQ-018 IDLE behaviour: on in_valid=1, the block SHALL capture op, opA and opB into internal registers and go to EXEC; otherwise it SHALL stay in IDLE.
REQ-019 The rca_* outputs SHALL be driven only from the captured registers, never combinationally from opA or opB.
REQ-020 Adder drive per op:
- ADD: rca_A=opA, rca_B=opB, rca_Cin=0.
- SUB: rca_A=opA, rca_B=opB, rca_Cin=1.
- ACC: rca_A=acc, rca_B=opB, rca_Cin=0.
- CLR: rca_A=0, rca_B=0, rca_Cin=0.
REQ-021 EXEC is exactly one cycle, which allows the full ripple settle. At the EXEC->HOLD edge the block SHALL register:
- result<=rca_Sum
- flag_c<=rca_Cout
- flag_z<=(rca_Sum==0)
- flag_n<=rca_Sum[7]
- flag_v<=(rca_A[7]==(rca_B[7]^rca_Cin)) && (rca_Sum[7]!=rca_A[7])
REQ-022 For CLR, result, acc and all four flags SHALL be 0, except flag_z, which SHALL be 1.
REQ-023 acc SHALL load rca_Sum at the EXEC->HOLD edge for ADD, SUB and ACC.
REQ-024 For SUB, flag_c=1 SHALL mean no borrow (opA>=opB, unsigned).
REQ-025 Arithmetic SHALL wrap modulo 256; the carry out is visible only in flag_c.
REQ-026 out_valid SHALL be 1 only in HOLD.
REQ-027 In HOLD, result, flags and acc SHALL be held stable.
REQ-028 In HOLD, out_ready=1 SHALL go to IDLE on the next edge; otherwise the block SHALL stay in HOLD indefinitely.
REQ-029 Latency: a request accepted at edge N SHALL give out_valid=1 after edge N+2; minimum spacing between requests SHALL be 3 cycles.
REQ-030 in_valid SHALL be ignored outside IDLE, and no request SHALL be queued.
REQ-031 out_ready SHALL be ignored outside HOLD.
REQ-032 acc SHALL persist across operations and SHALL be changed only as given in REQ-022 and REQ-023, and by reset.

Reset
REQ-033 rst=1 SHALL immediately, without waiting for a clock, force:
- state to IDLE
- result, acc and all flags to 0
- the captured registers, and therefore rca_A, rca_B and rca_Cin, to 0
- out_valid and in_ready to 0
REQ-034 Reset asserted in EXEC or HOLD SHALL discard the operation in flight with no partial update.
REQ-035 in_ready SHALL be 1 in the first cycle after rst falls.

Verification
REQ-036 ADD opA=0x7F, opB=0x01 -> result=0x80, c=0, z=0, n=1, v=1; out_valid 2 cycles after acceptance.
REQ-037 SUB 0x05-0x05 -> result=0x00, c=1, z=1, n=0, v=0; rca_Cin=1 during EXEC.
REQ-038 SUB 0x03-0x05 -> result=0xFE, c=0, n=1, v=0; SUB 0x80-0x01 -> result=0x7F, v=1.
REQ-039 Run CLR, then ACC opB=0xFF, then ACC opB=0xFF:
- after CLR: acc=0x00, z=1
- after the first ACC: acc=0xFF, c=0
- after the second ACC: acc=0xFE, c=1
REQ-040 Hold out_ready=0 for 5 cycles in HOLD while pulsing in_valid with new operands -> result, flags and acc stay unchanged, and in_ready stays 0 throughout.
REQ-041 Assert rst mid-EXEC of ADD 0x10+0x20 -> outputs 0 immediately with no clock needed, acc stays 0x00, and the next ADD 0x01+0x01 after release gives 0x02.
